uart_rx_ctrl: RTL and testbench

//  Sequencing controller for the UART receiver (DATA_WIDTH/TIME oversampling receiver).
//  It generates the receiver's s_tick from a programmable divisor and captures each

---
 rtl/uart_rx_ctrl.sv | 118 +++++++++++
 tb/tb_uart_rx_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the oversampling UART receiver.
//   Generates the receiver's s_tick from a programmable divisor, captures a frame
//   on each rising edge of rx_done_tick, buffers frames in a small FIFO and presents
//   them on a valid/ready interface with sticky overrun reporting.
// Ports:
//   clk, reset        system clock; asynchronous active-low reset
//   enable            run tick generator and accept new frames
//   divisor           s_tick period is divisor+1 clk cycles
//   s_tick            oversample tick to the receiver
//   rx_done_tick      receiver done level (rising edge = one frame)
//   rx_data           receiver data, sampled on the rising edge of rx_done_tick
//   m_data, m_valid   FIFO head frame and its valid flag
//   m_ready           downstream accepts; pop when m_valid & m_ready
//   overrun           sticky frame-dropped flag; clr_overrun clears it
//   fifo_count        frames currently buffered
module uart_rx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [DIV_WIDTH-1:0]          divisor,
   output logic                          s_tick,
   input  logic                          rx_done_tick,
   input  logic [DATA_WIDTH-1:0]         rx_data,
   output logic [DATA_WIDTH-1:0]         m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          overrun,
   input  logic                          clr_overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StDisabled, StRun, StDrain} state_e;

   state_e                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   tick_cnt_q, tick_cnt_d;
   logic                   done_q;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]        count_q, count_d;
   logic                   overrun_q, overrun_d;

   logic push, pop, full, push_acc, overrun_set;

   // Controller FSM and tick generator
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = '0;
      s_tick     = 1'b0;
      unique case (state_q)
         StDisabled: if (enable) state_d = StRun;
         StRun:      if (!enable) state_d = StDrain;
         StDrain: begin
            if (enable)                 state_d = StRun;
            else if (count_q == '0)     state_d = StDisabled;
         end
         default:    state_d = StDisabled;
      endcase
      if (state_q == StRun) begin
         if (tick_cnt_q == divisor) begin
            s_tick     = 1'b1;
            tick_cnt_d = '0;
         end else if (tick_cnt_q > divisor) begin
            // Divisor shrank below the running count: resync without a tick.
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + DIV_WIDTH'(1);
         end
      end
   end

   // FIFO control
   always_comb begin
      push        = rx_done_tick & ~done_q & (state_q == StRun);
      m_valid     = (count_q != '0);
      pop         = m_valid & m_ready;
      full        = (count_q == CntW'(FIFO_DEPTH));
      // A pop on a full FIFO frees the slot the simultaneous push needs.
      push_acc    = push & (~full | pop);
      overrun_set = push & full & ~pop;
      count_d     = count_q + CntW'(push_acc) - CntW'(pop);
      overrun_d   = overrun_set | (overrun_q & ~clr_overrun);
      m_data      = m_valid ? mem_q[rd_ptr_q] : '0;
      overrun     = overrun_q;
      fifo_count  = count_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StDisabled;
         tick_cnt_q <= '0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         done_q     <= rx_done_tick;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         if (push_acc) begin
            mem_q[wr_ptr_q] <= rx_data;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl.
module tb_uart_rx_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] divisor;
   logic        s_tick;
   logic        rx_done_tick;
   logic [7:0]  rx_data;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        overrun;
   logic        clr_overrun;
   logic [2:0]  fifo_count;

   int tests_run    = 0;
   int tests_failed = 0;

   uart_rx_ctrl #(
      .DATA_WIDTH(8),
      .DIV_WIDTH(16),
      .FIFO_DEPTH(4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .divisor      (divisor),
      .s_tick       (s_tick),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .m_data       (m_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .overrun      (overrun),
      .clr_overrun  (clr_overrun),
      .fifo_count   (fifo_count)
   );

   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One rising edge of rx_done_tick carrying d, then back low.
   task automatic send_frame(input logic [7:0] d);
      rx_data      = d;
      rx_done_tick = 1'b1;
      step();
      rx_done_tick = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      enable       = 1'b0;
      divisor      = 16'd3;
      rx_done_tick = 1'b0;
      rx_data      = 8'h00;
      m_ready      = 1'b0;
      clr_overrun  = 1'b0;
      step();
      step();
      tests_run++;
      if ({s_tick, m_valid, m_data, overrun, fifo_count} !== 13'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got tick=%b valid=%b data=%h ovr=%b cnt=%0d required all 0",
                  s_tick, m_valid, m_data, overrun, fifo_count);
      end
      reset = 1'b1;
      step();
      tests_run++;
      if (s_tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL disabled_no_tick: got %b required 0", s_tick);
      end
   endtask

   task automatic test_tick();
      bit found = 0;
      enable  = 1'b1;
      divisor = 16'd3;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (s_tick === 1'b1) found = 1;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL tick_first: got no s_tick within 10 cycles required a tick");
      end
      for (int i = 1; i <= 8; i++) begin
         step();
         tests_run++;
         if (s_tick !== ((i % 4) == 0)) begin
            tests_failed++;
            $display("FAIL tick_div3[%0d]: got %b required %b", i, s_tick, (i % 4) == 0);
         end
      end
      divisor = 16'd0;
      step();
      step();
      for (int i = 0; i < 5; i++) begin
         tests_run++;
         if (s_tick !== 1'b1) begin
            tests_failed++;
            $display("FAIL tick_div0[%0d]: got %b required 1", i, s_tick);
         end
         step();
      end
   endtask

   task automatic test_single_frame();
      m_ready      = 1'b1;
      rx_data      = 8'hA5;
      rx_done_tick = 1'b1;
      step();
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
         tests_failed++;
         $display("FAIL single_beat: got valid=%b data=%h required valid=1 data=a5",
                  m_valid, m_data);
      end
      for (int i = 0; i < 9; i++) begin
         step();
         tests_run++;
         if (m_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_no_repeat[%0d]: got valid=%b required 0", i, m_valid);
         end
      end
      rx_done_tick = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      m_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i));
      tests_run++;
      if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL ovf_state: got cnt=%0d ovr=%b required cnt=4 ovr=1", fifo_count, overrun);
      end
      step();
      tests_run++;
      if (m_data !== 8'h01) begin
         tests_failed++;
         $display("FAIL ovf_hold: got %h required 01", m_data);
      end
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tests_run++;
         if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
            tests_failed++;
            $display("FAIL ovf_order[%0d]: got valid=%b data=%h required valid=1 data=%h",
                     i, m_valid, m_data, 8'(i));
         end
         step();
      end
      tests_run++;
      if (m_valid !== 1'b0 || fifo_count !== 3'd0) begin
         tests_failed++;
         $display("FAIL ovf_lost5: got valid=%b cnt=%0d required valid=0 cnt=0",
                  m_valid, fifo_count);
      end
      m_ready     = 1'b0;
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      tests_run++;
      if (overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL ovf_clear: got %b required 0", overrun);
      end
   endtask

   task automatic test_full_push_pop();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i));
      rx_data      = 8'h14;
      rx_done_tick = 1'b1;
      m_ready      = 1'b1;
      step();
      rx_done_tick = 1'b0;
      m_ready      = 1'b0;
      tests_run++;
      if (fifo_count !== 3'd4 || overrun !== 1'b0 || m_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL full_pushpop: got cnt=%0d ovr=%b head=%h required cnt=4 ovr=0 head=11",
                  fifo_count, overrun, m_data);
      end
      step();
      m_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tests_run++;
         if (m_valid !== 1'b1 || m_data !== 8'h10 + 8'(i)) begin
            tests_failed++;
            $display("FAIL full_order[%0d]: got valid=%b data=%h required valid=1 data=%h",
                     i, m_valid, m_data, 8'h10 + 8'(i));
         end
         step();
      end
      tests_run++;
      if (m_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL full_empty: got valid=%b required 0", m_valid);
      end
      m_ready = 1'b0;
   endtask

   task automatic test_drain();
      send_frame(8'h20);
      send_frame(8'h21);
      tests_run++;
      if (fifo_count !== 3'd2) begin
         tests_failed++;
         $display("FAIL drain_fill: got cnt=%0d required 2", fifo_count);
      end
      enable = 1'b0;
      step();
      tests_run++;
      if (s_tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_tick: got %b required 0", s_tick);
      end
      send_frame(8'h22);
      tests_run++;
      if (fifo_count !== 3'd2 || s_tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_ignore: got cnt=%0d tick=%b required cnt=2 tick=0",
                  fifo_count, s_tick);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tests_run++;
         if (m_valid !== 1'b1 || m_data !== 8'h20 + 8'(i)) begin
            tests_failed++;
            $display("FAIL drain_order[%0d]: got valid=%b data=%h required valid=1 data=%h",
                     i, m_valid, m_data, 8'h20 + 8'(i));
         end
         step();
      end
      m_ready = 1'b0;
      step();
      step();
      send_frame(8'h23);
      tests_run++;
      if (fifo_count !== 3'd0 || m_valid !== 1'b0 || s_tick !== 1'b0) begin
         tests_failed++;
         $display("FAIL drain_disabled: got cnt=%0d valid=%b tick=%b required 0 0 0",
                  fifo_count, m_valid, s_tick);
      end
   endtask

   task automatic test_async_reset();
      enable  = 1'b1;
      divisor = 16'd0;
      step();
      step();
      tests_run++;
      if (s_tick !== 1'b1) begin
         tests_failed++;
         $display("FAIL rerun_tick: got %b required 1", s_tick);
      end
      for (int i = 0; i < 5; i++) send_frame(8'h30 + 8'(i));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      tests_run++;
      if (fifo_count !== 3'd3 || overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL prereset: got cnt=%0d ovr=%b required cnt=3 ovr=1", fifo_count, overrun);
      end
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if ({s_tick, m_valid, m_data, overrun, fifo_count} !== 13'd0) begin
         tests_failed++;
         $display("FAIL async_reset: got tick=%b valid=%b data=%h ovr=%b cnt=%0d required all 0",
                  s_tick, m_valid, m_data, overrun, fifo_count);
      end
      step();
      reset = 1'b1;
      step();
      rx_data      = 8'h5A;
      rx_done_tick = 1'b1;
      m_ready      = 1'b1;
      step();
      rx_done_tick = 1'b0;
      tests_run++;
      if (m_valid !== 1'b1 || m_data !== 8'h5A) begin
         tests_failed++;
         $display("FAIL post_reset_frame: got valid=%b data=%h required valid=1 data=5a",
                  m_valid, m_data);
      end
      step();
      m_ready = 1'b0;
      tests_run++;
      if (m_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_pop: got valid=%b required 0", m_valid);
      end
   endtask

   task automatic test_clr_collision();
      for (int i = 0; i < 4; i++) send_frame(8'h40 + 8'(i));
      rx_data      = 8'h44;
      rx_done_tick = 1'b1;
      clr_overrun  = 1'b1;
      step();
      rx_done_tick = 1'b0;
      clr_overrun  = 1'b0;
      tests_run++;
      if (overrun !== 1'b1 || fifo_count !== 3'd4 || m_data !== 8'h40) begin
         tests_failed++;
         $display("FAIL clr_collision: got ovr=%b cnt=%0d head=%h required ovr=1 cnt=4 head=40",
                  overrun, fifo_count, m_data);
      end
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      tests_run++;
      if (overrun !== 1'b0) begin
         tests_failed++;
         $display("FAIL clr_alone: got %b required 0", overrun);
      end
   endtask

   initial begin
      test_reset();
      test_tick();
      test_single_frame();
      test_overflow();
      test_full_push_pop();
      test_drain();
      test_async_reset();
      test_clr_collision();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
